// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control FSM.
// The FSM and its testbench refer to control encodings only by these names.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXECR, EXECI, ALUWB, MULLO, MULHI,
        FPEXEC, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
    } state_t;

    typedef enum logic [2:0] {
        K_UNDEF, K_DP, K_MUL, K_UMULL, K_MEM, K_BR, K_FP
    } kind_t;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0110;
    localparam logic [3:0] ALU_ORR   = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b0100;
    localparam logic [3:0] ALU_UMULL = 4'b0101;
    localparam logic [3:0] ALU_NONE  = 4'b0000;

    localparam logic [1:0] FPU_FADD = 2'b00;
    localparam logic [1:0] FPU_FMUL = 2'b01;
    localparam logic [1:0] FPU_IDLE = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_LO  = 2'b10;
    localparam logic [1:0] RES_HI  = 2'b11;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_FP  = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] alu_ctrl;
        logic [1:0] fpu_op;
        logic       imm;
        logic       set_flags;
        logic       load;
        logic       rd_pc;
    } dec_t;

    // ALU_NONE marks a data-processing command this datapath cannot execute.
    function automatic logic [3:0] dp_alu_ctrl(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the FSM (master) and the multicycle datapath (slave).
interface multicycle_ctrl_fsm_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, NextPC, Branch, PCS, RegWrite, IRWrite, AdrSrc;
    logic        WAsel, ResultWEn, AandBWrite, RA2Sel, MemWrite;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, FPUOp;
    logic [3:0]  ALUControl;
    logic [3:0]  Flags;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, NextPC, Branch, PCS, RegWrite, IRWrite, AdrSrc,
               WAsel, ResultWEn, AandBWrite, RA2Sel, MemWrite,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, FPUOp,
               ALUControl, Flags
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, NextPC, Branch, PCS, RegWrite, IRWrite, AdrSrc,
               WAsel, ResultWEn, AandBWrite, RA2Sel, MemWrite,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, FPUOp,
               ALUControl, Flags
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_cond_check.sv
// ARM condition-code evaluation against the architectural NZCV flags.
// Condition 1111 is treated as "never" so such instructions are squashed.
module multicycle_ctrl_fsm_cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = ~(n ^ v);
            4'b1011: cond_ex = n ^ v;
            4'b1100: cond_ex = ~z & ~(n ^ v);
            4'b1101: cond_ex = z | (n ^ v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle ALU/FPU/long-multiply datapath.
// Outputs are a decode of the registered state and the (registered) IR contents.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_fsm_if.master bus
);

    state_t     state_reg, state_next;
    logic [3:0] flags_reg;
    dec_t       dec;
    logic       cond_ex;
    logic [1:0] op;
    logic [3:0] cmd_alu;

    // Register-number fields are consumed by the datapath, not by control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

    assign op      = bus.Instr[27:26];
    assign cmd_alu = dp_alu_ctrl(bus.Instr[24:21]);

    always_comb begin
        dec = '{kind: K_UNDEF, alu_ctrl: ALU_NONE, fpu_op: FPU_IDLE,
                imm: bus.Instr[25], set_flags: bus.Instr[20],
                load: bus.Instr[20], rd_pc: (bus.Instr[15:12] == 4'hF)};
        case (op)
            OP_DP: begin
                if (bus.Instr[7:4] == 4'b1001) begin
                    dec.kind     = bus.Instr[23] ? K_UMULL : K_MUL;
                    dec.alu_ctrl = bus.Instr[23] ? ALU_UMULL : ALU_MUL;
                end else if (cmd_alu != ALU_NONE) begin
                    dec.kind     = K_DP;
                    dec.alu_ctrl = cmd_alu;
                end
            end
            OP_MEM: begin
                dec.kind     = K_MEM;
                dec.alu_ctrl = bus.Instr[23] ? ALU_ADD : ALU_SUB;
            end
            OP_BR:   dec.kind = K_BR;
            default: begin
                dec.kind   = K_FP;
                dec.fpu_op = bus.Instr[21] ? FPU_FMUL : FPU_FADD;
            end
        endcase
    end

    multicycle_ctrl_fsm_cond_check u_cond_check (
        .cond    (bus.Instr[31:28]),
        .flags   (flags_reg),
        .cond_ex (cond_ex)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                if (!cond_ex || dec.kind == K_UNDEF) begin
                    state_next = FETCH;
                end else begin
                    case (dec.kind)
                        K_MEM:          state_next = MEMADR;
                        K_BR:           state_next = BRANCH;
                        K_FP:           state_next = FPEXEC;
                        K_DP:           state_next = dec.imm ? EXECI : EXECR;
                        K_MUL, K_UMULL: state_next = EXECR;
                        default:        state_next = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: state_next = (dec.kind == K_UMULL) ? MULLO : ALUWB;
            MULLO:  state_next = MULHI;
            FPEXEC: state_next = ALUWB;
            MEMADR: state_next = dec.load ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RESET_STATE;
            flags_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            if ((state_reg == EXECR || state_reg == EXECI) &&
                dec.kind == K_DP && dec.set_flags) begin
                flags_reg <= bus.ALUFlags;
            end
        end
    end

    assign bus.Flags = flags_reg;

    // Outputs are forced idle while reset is high so no strobe fires in the reset cycle.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.NextPC     = 1'b0;
        bus.Branch     = 1'b0;
        bus.PCS        = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.WAsel      = 1'b0;
        bus.ResultWEn  = 1'b0;
        bus.AandBWrite = 1'b0;
        bus.RA2Sel     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALU;
        bus.ImmSrc     = IMM_DP;
        bus.FPUOp      = FPU_IDLE;
        bus.ALUControl = ALU_NONE;
        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.NextPC  = 1'b1;
                end
                DECODE: begin
                    bus.AandBWrite = 1'b1;
                    bus.RA2Sel     = (op == OP_MEM) && !bus.Instr[20];
                end
                EXECR, EXECI: begin
                    bus.ALUSrcB    = (state_reg == EXECI) ? SRCB_IMM : SRCB_REG;
                    bus.ALUControl = dec.alu_ctrl;
                    bus.ResultWEn  = 1'b1;
                end
                ALUWB: begin
                    if (dec.kind != K_FP) begin
                        bus.ALUSrcB    = (dec.kind == K_DP && dec.imm) ? SRCB_IMM : SRCB_REG;
                        bus.ALUControl = dec.alu_ctrl;
                    end
                    if (dec.kind == K_MUL) begin
                        bus.WAsel    = 1'b1;
                        bus.RegWrite = 1'b1;
                    end else if (dec.rd_pc) begin
                        bus.PCWrite = 1'b1;
                        bus.PCS     = 1'b1;
                    end else begin
                        bus.RegWrite = 1'b1;
                    end
                end
                MULLO: begin
                    bus.ResultSrc = RES_LO;
                    bus.RegWrite  = 1'b1;
                end
                MULHI: begin
                    bus.ResultSrc = RES_HI;
                    bus.WAsel     = 1'b1;
                    bus.RegWrite  = 1'b1;
                end
                FPEXEC: begin
                    bus.FPUOp     = dec.fpu_op;
                    bus.ResultWEn = 1'b1;
                end
                MEMADR, MEMRD, MEMWR: begin
                    bus.ALUSrcB    = SRCB_IMM;
                    bus.ImmSrc     = IMM_MEM;
                    bus.ALUControl = dec.alu_ctrl;
                    bus.AdrSrc     = (state_reg != MEMADR);
                    bus.MemWrite   = (state_reg == MEMWR);
                end
                MEMWB: begin
                    bus.ResultSrc = RES_MEM;
                    bus.RegWrite  = 1'b1;
                end
                BRANCH: begin
                    bus.ImmSrc  = IMM_BR;
                    bus.PCWrite = 1'b1;
                    bus.Branch  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench: a per-instruction cycle plan is built from the ISA rules and
// compared cycle by cycle against the control word the FSM presents.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic       pc_write, next_pc, branch, pcs, reg_write, ir_write, adr_src;
        logic       wa_sel, result_wen, a_b_write, ra2_sel, mem_write;
        logic [1:0] reg_src, alu_src_a, alu_src_b, result_src, imm_src, fpu_op;
        logic [3:0] alu_control;
        logic [3:0] flags;
    } cw_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cw_t        exp_q[$];
    string      tag_q[$];
    cw_t        plan[$];
    string      plan_tag[$];
    logic [3:0] mflags;
    int         checks = 0;
    int         errors = 0;

    function automatic cw_t idle_cw(input logic [3:0] f);
        cw_t c;
        c = '0;
        c.fpu_op = 2'b11;
        c.flags  = f;
        return c;
    endfunction

    // Condition truth from the ARM table: even codes test, odd codes invert.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0]) r = !r;
        if (cond == 4'b1111) r = 1'b0;
        return r;
    endfunction

    function automatic cw_t sample_dut();
        cw_t a;
        a.pc_write    = bus.PCWrite;    a.next_pc    = bus.NextPC;
        a.branch      = bus.Branch;     a.pcs        = bus.PCS;
        a.reg_write   = bus.RegWrite;   a.ir_write   = bus.IRWrite;
        a.adr_src     = bus.AdrSrc;     a.wa_sel     = bus.WAsel;
        a.result_wen  = bus.ResultWEn;  a.a_b_write  = bus.AandBWrite;
        a.ra2_sel     = bus.RA2Sel;     a.mem_write  = bus.MemWrite;
        a.reg_src     = bus.RegSrc;     a.alu_src_a  = bus.ALUSrcA;
        a.alu_src_b   = bus.ALUSrcB;    a.result_src = bus.ResultSrc;
        a.imm_src     = bus.ImmSrc;     a.fpu_op     = bus.FPUOp;
        a.alu_control = bus.ALUControl; a.flags      = bus.Flags;
        return a;
    endfunction

    task automatic add(input cw_t c, input string t);
        plan.push_back(c);
        plan_tag.push_back(t);
    endtask

    task automatic writeback(inout cw_t c, input logic [3:0] rd);
        if (rd == 4'hF) begin
            c.pc_write = 1'b1;
            c.pcs      = 1'b1;
        end else begin
            c.reg_write = 1'b1;
        end
    endtask

    task automatic build_plan(input logic [31:0] ins, input logic [3:0] af);
        cw_t        c, base;
        logic [3:0] old_f, new_f, aluc;
        logic [1:0] op;
        logic       is_mul, defined;
        plan.delete();
        plan_tag.delete();
        old_f   = mflags;
        new_f   = mflags;
        op      = ins[27:26];
        is_mul  = (op == 2'b00) && (ins[7:4] == 4'b1001);
        aluc    = 4'b0000;
        defined = 1'b1;
        if (op == 2'b00 && !is_mul) begin
            case (ins[24:21])
                4'b0100: aluc = 4'b0010;
                4'b0010: aluc = 4'b0011;
                4'b0000: aluc = 4'b0110;
                4'b1100: aluc = 4'b0111;
                default: defined = 1'b0;
            endcase
        end
        c = idle_cw(old_f); c.ir_write = 1; c.pc_write = 1; c.next_pc = 1;
        add(c, "FETCH");
        c = idle_cw(old_f); c.a_b_write = 1; c.ra2_sel = (op == 2'b01) && !ins[20];
        add(c, "DECODE");
        if (!defined || !cond_ok(ins[31:28], old_f)) return;
        if (is_mul) begin
            base = idle_cw(old_f);
            base.alu_control = ins[23] ? 4'b0101 : 4'b0100;
            c = base; c.result_wen = 1; add(c, "EXEC_MUL");
            if (ins[23]) begin
                c = idle_cw(old_f); c.result_src = 2'b10; c.reg_write = 1; add(c, "MUL_LO");
                c = idle_cw(old_f); c.result_src = 2'b11; c.wa_sel = 1; c.reg_write = 1;
                add(c, "MUL_HI");
            end else begin
                c = base; c.wa_sel = 1; c.reg_write = 1; add(c, "MUL_WB");
            end
        end else begin
            case (op)
                2'b00: begin
                    if (ins[20]) new_f = af;
                    base = idle_cw(old_f);
                    base.alu_src_b = ins[25] ? 2'b01 : 2'b00;
                    base.alu_control = aluc;
                    c = base; c.result_wen = 1; add(c, "EXEC_DP");
                    c = base; c.flags = new_f; writeback(c, ins[15:12]); add(c, "DP_WB");
                end
                2'b01: begin
                    base = idle_cw(old_f);
                    base.alu_src_b = 2'b01; base.imm_src = 2'b01;
                    base.alu_control = ins[23] ? 4'b0010 : 4'b0011;
                    add(base, "MEM_ADDR");
                    c = base; c.adr_src = 1;
                    if (ins[20]) begin
                        add(c, "MEM_READ");
                        c = idle_cw(old_f); c.result_src = 2'b01; c.reg_write = 1;
                        add(c, "MEM_WB");
                    end else begin
                        c.mem_write = 1; add(c, "MEM_WRITE");
                    end
                end
                2'b10: begin
                    c = idle_cw(old_f); c.imm_src = 2'b10; c.pc_write = 1; c.branch = 1;
                    add(c, "BRANCH");
                end
                default: begin
                    c = idle_cw(old_f); c.fpu_op = ins[21] ? 2'b01 : 2'b00; c.result_wen = 1;
                    add(c, "FP_EXEC");
                    c = idle_cw(old_f); writeback(c, ins[15:12]); add(c, "FP_WB");
                end
            endcase
        end
        mflags = new_f;
    endtask

    task automatic step(input int i, input logic [31:0] ins, input logic [3:0] af);
        if (i == 0) bus.ALUFlags = 4'($urandom);
        if (i == 1) begin
            bus.Instr    = ins;
            bus.ALUFlags = af;
        end
        exp_q.push_back(plan[i]);
        tag_q.push_back(plan_tag[i]);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
        build_plan(ins, af);
        for (int i = 0; i < plan.size(); i++) step(i, ins, af);
        $display("instr %08h cycles %0d flags %b", ins, plan.size(), mflags);
    endtask

    // Abort a store in its write cycle with reset; expects idle outputs then FETCH with Flags=0.
    task automatic run_reset_mid_str(input logic [31:0] ins);
        build_plan(ins, 4'b0000);
        for (int i = 0; i < plan.size() - 1; i++) step(i, ins, 4'b0000);
        reset = 1'b1;
        exp_q.push_back(idle_cw(mflags));
        tag_q.push_back("RESET_IN_MEMWR");
        @(posedge clk); #1;
        reset  = 1'b0;
        mflags = 4'b0000;
        $display("instr %08h aborted by reset in write cycle", ins);
    endtask

    initial begin
        cw_t   act, expv;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                t    = tag_q.pop_front();
                act  = sample_dut();
                checks++;
                if (act !== expv) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", t, act, expv);
                end
                checks++;
                if (act.pc_write && (int'(act.next_pc) + int'(act.branch) + int'(act.pcs)) != 1) begin
                    errors++;
                    $display("FAIL %s pc_source_onehot: got %b%b%b required exactly one",
                             t, act.next_pc, act.branch, act.pcs);
                end
                checks++;
                if (act.mem_write && act.reg_write) begin
                    errors++;
                    $display("FAIL %s write_exclusive: got MemWrite=1 RegWrite=1 required not both", t);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        bus.Instr    = 32'h0;
        bus.ALUFlags = 4'h0;
        mflags       = 4'b0000;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(idle_cw(4'b0000));
            tag_q.push_back("RESET_IDLE");
            @(posedge clk); #1;
        end
        reset = 1'b0;

        run_instr(32'hE2921000, 4'b0100);  // ADDS r1,r2,#0 -> Z set
        run_instr(32'h10811001, 4'b1111);  // ADDNE squashed by Z=1
        run_instr(32'hE0854392, 4'b1010);  // UMULL r4,r5,r2,r3
        run_instr(32'hE5010004, 4'b0000);  // STR, offset subtracted
        run_instr(32'hEC201000, 4'b0000);  // FMUL
        run_instr(32'hE0813002, 4'b0000);  // ADD r3,r1,r2
        run_instr(32'hE081F002, 4'b0000);  // ADD pc -> PCS path
        run_instr(32'hEA000010, 4'b0000);  // B
        run_instr(32'hE5910004, 4'b0000);  // LDR
        run_instr(32'hE0060392, 4'b0000);  // MUL r6
        run_instr(32'hE0221003, 4'b0110);  // EOR: undefined command
        run_instr(32'hF0811002, 4'b0110);  // cond 1111 never executes
        run_instr(32'hE0521003, 4'b1001);  // SUBS -> flags 1001
        run_reset_mid_str(32'hE5010004);

        for (int k = 0; k < 300; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            if (ins[27:26] == 2'b00 && ins[7:4] != 4'b1001 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: ins[24:21] = 4'b0100;
                    1: ins[24:21] = 4'b0010;
                    2: ins[24:21] = 4'b0000;
                    default: ins[24:21] = 4'b1100;
                endcase
            end
            if ($urandom_range(0, 9) == 0) ins[15:12] = 4'hF;
            run_instr(ins, 4'($urandom));
            if ($urandom_range(0, 49) == 0) run_reset_mid_str(32'hE5010004);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
